// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - requester, CPU and memory bus bundle for the VRAM arbiter
interface vram_arbiter_if #(
  parameter int STALL_W = 9
);
  logic               lcd_en;
  logic [1:0]         ppu_mode;
  logic               bg_req;
  logic [15:0]        bg_addr;
  logic               bg_gnt;
  logic               bg_rvalid;
  logic [7:0]         bg_rdata;
  logic               spr_req;
  logic [15:0]        spr_addr;
  logic               spr_lock;
  logic               spr_gnt;
  logic               spr_rvalid;
  logic [7:0]         spr_rdata;
  logic               cpu_req;
  logic               cpu_we;
  logic [15:0]        cpu_addr;
  logic [7:0]         cpu_wdata;
  logic               cpu_ack;
  logic [7:0]         cpu_rdata;
  logic               vram_en;
  logic               vram_we;
  logic [12:0]        vram_addr;
  logic [7:0]         vram_wdata;
  logic [7:0]         vram_rdata;
  logic [STALL_W-1:0] bg_stall_cnt;
  logic               err;

  modport slave (
    input  lcd_en, ppu_mode,
    input  bg_req, bg_addr, spr_req, spr_addr, spr_lock,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_rdata,
    output bg_gnt, bg_rvalid, bg_rdata, spr_gnt, spr_rvalid, spr_rdata,
    output cpu_ack, cpu_rdata, vram_en, vram_we, vram_addr, vram_wdata,
    output bg_stall_cnt, err
  );

  modport master (
    output lcd_en, ppu_mode,
    output bg_req, bg_addr, spr_req, spr_addr, spr_lock,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_rdata,
    input  bg_gnt, bg_rvalid, bg_rdata, spr_gnt, spr_rvalid, spr_rdata,
    input  cpu_ack, cpu_rdata, vram_en, vram_we, vram_addr, vram_wdata,
    input  bg_stall_cnt, err
  );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM owner shared by BG fetcher, sprite fetcher and CPU
module vram_arbiter #(
  parameter int STALL_W = 9
) (
  input  logic          clk,
  input  logic          reset,
  vram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    OWN_NONE,
    OWN_BG,
    OWN_SPR,
    OWN_CPU_RD,
    OWN_CPU_WR,
    OWN_CPU_FF
  } owner_e;

  owner_e             owner_q, owner_d;
  logic               cpu_ff_q, cpu_ff_d;
  logic               cpu_ff_rd_q, cpu_ff_rd_d;
  logic [7:0]         bg_rdata_q, bg_rdata_d;
  logic [7:0]         spr_rdata_q, spr_rdata_d;
  logic [7:0]         cpu_rdata_q, cpu_rdata_d;
  logic [1:0]         prev_mode_q;
  logic [STALL_W-1:0] stall_q, stall_d, stall_vis;
  logic               err_q, err_d;

  logic               locked;
  logic               bg_win, spr_win, cpu_win, cpu_blocked, mem_en;
  logic               addr_bad, stall_clr, stall_inc;
  logic [15:0]        win_addr;

  assign locked      = bus.lcd_en && (bus.ppu_mode == 2'd3);
  assign spr_win     = locked && bus.spr_req;
  assign bg_win      = locked && bus.bg_req && !bus.spr_req && !bus.spr_lock;
  assign cpu_win     = !locked && bus.cpu_req;
  assign cpu_blocked = locked && bus.cpu_req;
  assign mem_en      = spr_win || bg_win || cpu_win;

  always_comb begin
    win_addr = bus.cpu_addr;
    if (spr_win) begin
      win_addr = bus.spr_addr;
    end else if (bg_win) begin
      win_addr = bus.bg_addr;
    end
  end

  assign bus.bg_gnt     = bg_win;
  assign bus.spr_gnt    = spr_win;
  assign bus.vram_en    = mem_en;
  assign bus.vram_we    = cpu_win && bus.cpu_we;
  assign bus.vram_addr  = win_addr[12:0];
  assign bus.vram_wdata = bus.cpu_wdata;

  // A blocked CPU access can coincide with a fetcher grant, so its ack is
  // tracked by cpu_ff_q independently of the memory owner.
  always_comb begin
    owner_d = OWN_NONE;
    if (spr_win) begin
      owner_d = OWN_SPR;
    end else if (bg_win) begin
      owner_d = OWN_BG;
    end else if (cpu_win) begin
      owner_d = bus.cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
    end else if (cpu_blocked) begin
      owner_d = OWN_CPU_FF;
    end
  end

  assign cpu_ff_d    = cpu_blocked;
  assign cpu_ff_rd_d = cpu_blocked && !bus.cpu_we;

  always_comb begin
    bg_rdata_d  = bg_rdata_q;
    spr_rdata_d = spr_rdata_q;
    cpu_rdata_d = cpu_rdata_q;
    if (owner_q == OWN_BG) begin
      bg_rdata_d = bus.vram_rdata;
    end
    if (owner_q == OWN_SPR) begin
      spr_rdata_d = bus.vram_rdata;
    end
    if (owner_q == OWN_CPU_RD) begin
      cpu_rdata_d = bus.vram_rdata;
    end else if (cpu_ff_rd_q) begin
      cpu_rdata_d = 8'hFF;
    end
  end

  assign bus.bg_rvalid  = (owner_q == OWN_BG);
  assign bus.bg_rdata   = bg_rdata_d;
  assign bus.spr_rvalid = (owner_q == OWN_SPR);
  assign bus.spr_rdata  = spr_rdata_d;
  assign bus.cpu_ack    = (owner_q == OWN_CPU_RD) || (owner_q == OWN_CPU_WR) ||
                          (owner_q == OWN_CPU_FF) || cpu_ff_q;
  assign bus.cpu_rdata  = cpu_rdata_d;

  // The counter reads zero already on the first mode-3 cycle, hence the bypass.
  assign stall_clr = (bus.ppu_mode == 2'd3) && (prev_mode_q != 2'd3);
  assign stall_vis = stall_clr ? '0 : stall_q;
  assign stall_inc = locked && bus.bg_req && !bg_win;

  always_comb begin
    stall_d = stall_vis;
    if (stall_inc && (stall_vis != '1)) begin
      stall_d = stall_vis + STALL_W'(1);
    end
  end

  assign bus.bg_stall_cnt = stall_vis;

  assign addr_bad = mem_en && (win_addr[15:13] != 3'b100);

  always_comb begin
    err_d = err_q;
    if (!locked && (bus.bg_req || bus.spr_req)) begin
      err_d = 1'b1;
    end
    if (addr_bad) begin
      err_d = 1'b1;
    end
    if (bus.bg_req && bus.spr_req && !bus.spr_lock) begin
      err_d = 1'b1;
    end
  end

  assign bus.err = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q     <= OWN_NONE;
      cpu_ff_q    <= 1'b0;
      cpu_ff_rd_q <= 1'b0;
      bg_rdata_q  <= 8'h00;
      spr_rdata_q <= 8'h00;
      cpu_rdata_q <= 8'h00;
      prev_mode_q <= 2'd0;
      stall_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      cpu_ff_q    <= cpu_ff_d;
      cpu_ff_rd_q <= cpu_ff_rd_d;
      bg_rdata_q  <= bg_rdata_d;
      spr_rdata_q <= spr_rdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      prev_mode_q <= bus.ppu_mode;
      stall_q     <= stall_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - randomized scoreboard bench for vram_arbiter
module tb_vram_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  vram_arbiter_if #(.STALL_W(9)) bus ();

  vram_arbiter #(.STALL_W(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Physical synchronous VRAM
  logic [7:0] mem [0:8191];
  always @(posedge clk) begin
    if (bus.vram_en) begin
      if (bus.vram_we) mem[bus.vram_addr] <= bus.vram_wdata;
      else bus.vram_rdata <= mem[bus.vram_addr];
    end
  end

  typedef struct {
    int         due;
    logic [7:0] data;
  } exp_t;

  exp_t       bg_q[$];
  exp_t       spr_q[$];
  exp_t       cpu_q[$];
  logic [7:0] shadow [0:8191];
  logic       err_m;
  int         stall_m;
  logic [1:0] prev_m;
  logic [7:0] cpu_last;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: decides the winner from the sharing rules and queues responses
  always @(negedge clk) begin
    logic       lk, e_spr, e_bg, e_cpu;
    logic [15:0] wa;
    int         vis;
    logic [7:0] d;
    if (reset) begin
      bg_q.delete(); spr_q.delete(); cpu_q.delete();
      err_m = 1'b0; stall_m = 0; prev_m = 2'd0; cpu_last = 8'h00;
    end else begin
      lk    = bus.lcd_en && bus.ppu_mode == 2'd3;
      e_spr = lk && bus.spr_req;
      e_bg  = lk && bus.bg_req && !bus.spr_req && !bus.spr_lock;
      e_cpu = !lk && bus.cpu_req;
      wa    = e_spr ? bus.spr_addr : e_bg ? bus.bg_addr : bus.cpu_addr;
      chk("spr_gnt", bus.spr_gnt, e_spr);
      chk("bg_gnt", bus.bg_gnt, e_bg);
      chk("vram_en", bus.vram_en, e_spr || e_bg || e_cpu);
      chk("vram_we", bus.vram_we, e_cpu && bus.cpu_we);
      chk("vram_wdata", bus.vram_wdata, bus.cpu_wdata);
      if (e_spr || e_bg || e_cpu) chk("vram_addr", bus.vram_addr, wa - 16'h8000);
      chk("err", bus.err, err_m);
      vis = (bus.ppu_mode == 2'd3 && prev_m != 2'd3) ? 0 : stall_m;
      chk("stall_cnt", bus.bg_stall_cnt, vis);

      if (e_spr) spr_q.push_back('{cyc + 1, shadow[bus.spr_addr - 16'h8000]});
      if (e_bg)  bg_q.push_back('{cyc + 1, shadow[bus.bg_addr - 16'h8000]});
      if (bus.cpu_req) begin
        if (lk) d = bus.cpu_we ? cpu_last : 8'hFF;
        else if (bus.cpu_we) begin
          d = cpu_last;
          shadow[bus.cpu_addr - 16'h8000] = bus.cpu_wdata;
        end else d = shadow[bus.cpu_addr - 16'h8000];
        cpu_last = d;
        cpu_q.push_back('{cyc + 1, d});
      end

      if (!lk && (bus.bg_req || bus.spr_req)) err_m = 1'b1;
      if ((e_spr || e_bg || e_cpu) && (wa < 16'h8000 || wa > 16'h9FFF)) err_m = 1'b1;
      if (bus.bg_req && bus.spr_req && !bus.spr_lock) err_m = 1'b1;
      stall_m = vis + ((lk && bus.bg_req && !e_bg && vis < 511) ? 1 : 0);
      prev_m  = bus.ppu_mode;
    end
  end

  // Monitor: pops an expectation whenever one is due and compares the DUT response
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_bg_rvalid", bus.bg_rvalid, 0);
      chk("rst_spr_rvalid", bus.spr_rvalid, 0);
      chk("rst_cpu_ack", bus.cpu_ack, 0);
      chk("rst_bg_rdata", bus.bg_rdata, 0);
      chk("rst_spr_rdata", bus.spr_rdata, 0);
      chk("rst_cpu_rdata", bus.cpu_rdata, 0);
      chk("rst_stall", bus.bg_stall_cnt, 0);
      chk("rst_err", bus.err, 0);
    end else begin
      if (bg_q.size() > 0 && bg_q[0].due == cyc) begin
        chk("bg_rvalid", bus.bg_rvalid, 1);
        chk("bg_rdata", bus.bg_rdata, bg_q[0].data);
        void'(bg_q.pop_front());
      end else chk("bg_rvalid_idle", bus.bg_rvalid, 0);
      if (spr_q.size() > 0 && spr_q[0].due == cyc) begin
        chk("spr_rvalid", bus.spr_rvalid, 1);
        chk("spr_rdata", bus.spr_rdata, spr_q[0].data);
        void'(spr_q.pop_front());
      end else chk("spr_rvalid_idle", bus.spr_rvalid, 0);
      if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
        chk("cpu_ack", bus.cpu_ack, 1);
        chk("cpu_rdata", bus.cpu_rdata, cpu_q[0].data);
        void'(cpu_q.pop_front());
      end else chk("cpu_ack_idle", bus.cpu_ack, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.bg_req  = 1'b0;
    bus.spr_req = 1'b0;
    bus.cpu_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic       lk;
    int         r, spr_pulses;
    logic [7:0] old;
    reset = 1'b1;
    bus.lcd_en = 1'b0; bus.ppu_mode = 2'd0; bus.spr_lock = 1'b0;
    bus.bg_req = 1'b0; bus.bg_addr = 16'h8000; bus.spr_req = 1'b0; bus.spr_addr = 16'h8000;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h8000; bus.cpu_wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 8192; i++) begin
      tick();
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
      bus.cpu_addr = 16'h8000 + 16'(i); bus.cpu_wdata = 8'($urandom);
    end

    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(15) == 0) bus.ppu_mode = 2'($urandom_range(3));
      if ($urandom_range(31) == 0) bus.lcd_en = ($urandom_range(3) != 0);
      if ($urandom_range(7) == 0) bus.spr_lock = !bus.spr_lock;
      lk = bus.lcd_en && bus.ppu_mode == 2'd3;
      bus.bg_addr  = 16'h8000 + 16'($urandom_range(8191));
      bus.spr_addr = 16'h8000 + 16'($urandom_range(8191));
      if (lk) begin
        r = $urandom_range(3);
        bus.bg_req  = (r == 1) || (r == 3);
        bus.spr_req = (r == 2) || (r == 3 && bus.spr_lock);
      end
      bus.cpu_req   = $urandom_range(1) == 1;
      bus.cpu_we    = $urandom_range(1) == 1;
      bus.cpu_addr  = 16'h8000 + 16'($urandom_range(8191));
      bus.cpu_wdata = 8'($urandom);
    end

    // LCD off: CPU write then read back
    tick();
    bus.lcd_en = 1'b0; bus.ppu_mode = 2'd0; bus.spr_lock = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h8010; bus.cpu_wdata = 8'h5A;
    @(negedge clk) chk("tp1_we", bus.vram_we, 1);
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h8010;
    @(negedge clk) chk("tp1_wack", bus.cpu_ack, 1);
    tick();
    @(negedge clk) chk("tp1_rack", bus.cpu_ack, 1);
    chk("tp1_rdata", bus.cpu_rdata, 8'h5A);
    chk("tp1_err", bus.err, 0);

    // Mode 3: CPU locked out
    tick();
    bus.lcd_en = 1'b1; bus.ppu_mode = 2'd3;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h9800;
    @(negedge clk) chk("tp2_en", bus.vram_en, 0);
    tick();
    @(negedge clk) chk("tp2_ack", bus.cpu_ack, 1);
    chk("tp2_ff", bus.cpu_rdata, 8'hFF);
    old = shadow[0];
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h8000; bus.cpu_wdata = 8'h11;
    tick();
    bus.ppu_mode = 2'd0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h8000;
    tick();
    @(negedge clk) chk("tp2_old", bus.cpu_rdata, old);

    // BG read of 0x9800
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h9800; bus.cpu_wdata = 8'h42;
    tick();
    bus.ppu_mode = 2'd3; bus.bg_req = 1'b1; bus.bg_addr = 16'h9800;
    @(negedge clk) chk("tp3_gnt", bus.bg_gnt, 1);
    chk("tp3_addr", bus.vram_addr, 13'h1800);
    tick();
    @(negedge clk) chk("tp3_rvalid", bus.bg_rvalid, 1);
    chk("tp3_rdata", bus.bg_rdata, 8'h42);

    // Sprite burst blocks BG for 6 cycles
    tick();
    bus.ppu_mode = 2'd2;
    spr_pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.ppu_mode = 2'd3; bus.spr_lock = 1'b1;
      bus.bg_req = 1'b1; bus.bg_addr = 16'h9000 + 16'(i);
      bus.spr_req = (i % 2 == 0); bus.spr_addr = 16'h8000 + 16'(i * 4);
      @(negedge clk) chk("tp4_bg_gnt", bus.bg_gnt, 0);
      if (bus.spr_rvalid) spr_pulses++;
    end
    tick();
    bus.spr_lock = 1'b0; bus.bg_req = 1'b1; bus.bg_addr = 16'h9100;
    @(negedge clk) if (bus.spr_rvalid) spr_pulses++;
    chk("tp4_stall", bus.bg_stall_cnt, 6);
    chk("tp4_bg_gnt_after", bus.bg_gnt, 1);
    chk("tp4_spr_pulses", spr_pulses, 3);

    // Re-entry into mode 3 clears the counter
    tick();
    bus.ppu_mode = 2'd2;
    tick();
    bus.ppu_mode = 2'd3;
    @(negedge clk) chk("tp5_clear", bus.bg_stall_cnt, 0);

    // Sticky error, then reset during a sprite access
    tick();
    bus.ppu_mode = 2'd0; bus.bg_req = 1'b1; bus.bg_addr = 16'h8000;
    tick();
    @(negedge clk) chk("tp6_err", bus.err, 1);
    tick();
    @(negedge clk) chk("tp6_err_sticky", bus.err, 1);
    tick();
    bus.ppu_mode = 2'd3; bus.spr_req = 1'b1; bus.spr_addr = 16'h8100;
    tick();
    reset = 1'b1;
    @(negedge clk) chk("tp6_rst_rvalid", bus.spr_rvalid, 0);
    chk("tp6_rst_err", bus.err, 0);
    tick();
    reset = 1'b0;
    @(negedge clk) chk("tp6_post_rvalid", bus.spr_rvalid, 0);
    chk("tp6_post_err", bus.err, 0);
    tick();
    @(negedge clk) chk("q_empty", bg_q.size() + spr_q.size() + cpu_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
